// File: rtl/branch_predictor.sv
// Branch target buffer with saturating-counter direction prediction.
// Lookup is combinational from the fetch PC; training from the execute stage
// lands on the next rising edge. Two saturating counters track accepted
// updates and mispredicts.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush_i               invalidate all entries, drop same-cycle update
//   PCF_i                 fetch PC to look up
//   predict_taken_o       hit and counter MSB set
//   predict_pc_o          stored target when predicted taken, else PCF_i+4
//   update_en_i           resolved branch/jump this cycle
//   update_pc_i           PC of resolved instruction
//   update_taken_i        actual outcome
//   update_target_i       actual target
//   update_mispredict_i   pipeline was redirected
//   branch_count_o        accepted updates (saturating)
//   mispredict_count_o    accepted mispredicts (saturating)
module branch_predictor #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ENTRIES      = 16,
    parameter int unsigned COUNTER_BITS = 2,
    parameter int unsigned STAT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    output logic                  predict_taken_o,
    output logic [DATA_WIDTH-1:0] predict_pc_o,
    input  logic                  update_en_i,
    input  logic [DATA_WIDTH-1:0] update_pc_i,
    input  logic                  update_taken_i,
    input  logic [DATA_WIDTH-1:0] update_target_i,
    input  logic                  update_mispredict_i,
    output logic [STAT_WIDTH-1:0] branch_count_o,
    output logic [STAT_WIDTH-1:0] mispredict_count_o
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = DATA_WIDTH - IDX - 2;

    localparam logic [COUNTER_BITS-1:0] CTR_WT  = COUNTER_BITS'(1) << (COUNTER_BITS - 1);
    localparam logic [COUNTER_BITS-1:0] CTR_MAX = '1;
    localparam logic [STAT_WIDTH-1:0]   STAT_MAX = '1;

    logic                    valid_q  [ENTRIES];
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0]   target_q [ENTRIES];
    logic [COUNTER_BITS-1:0] ctr_q    [ENTRIES];

    logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;

    // Fetch-side decode and lookup
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;

    assign idx_f = PCF_i[IDX+1:2];
    assign tag_f = PCF_i[DATA_WIDTH-1:IDX+2];
    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

    assign predict_taken_o = hit_f && ctr_q[idx_f][COUNTER_BITS-1];
    assign predict_pc_o    = predict_taken_o ? target_q[idx_f]
                                             : PCF_i + DATA_WIDTH'(4);

    // Update-side decode; low PC bits are word-offset only
    logic [IDX-1:0]   idx_u;
    logic [TAG_W-1:0] tag_u;
    logic             hit_u;
    logic [1:0]       unused_upd_pc_lsb;

    assign idx_u = update_pc_i[IDX+1:2];
    assign tag_u = update_pc_i[DATA_WIDTH-1:IDX+2];
    assign hit_u = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    assign unused_upd_pc_lsb = update_pc_i[1:0];

    // Next-state for the single entry touched by an update, plus statistics
    logic                    ent_we;
    logic                    ent_valid_d;
    logic [TAG_W-1:0]        ent_tag_d;
    logic [DATA_WIDTH-1:0]   ent_target_d;
    logic [COUNTER_BITS-1:0] ent_ctr_d;

    always_comb begin
        ent_we        = 1'b0;
        ent_valid_d   = valid_q[idx_u];
        ent_tag_d     = tag_q[idx_u];
        ent_target_d  = target_q[idx_u];
        ent_ctr_d     = ctr_q[idx_u];
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (update_en_i) begin
            if (hit_u) begin
                ent_we = 1'b1;
                if (update_taken_i) begin
                    ent_target_d = update_target_i;
                    if (ctr_q[idx_u] != CTR_MAX) begin
                        ent_ctr_d = ctr_q[idx_u] + COUNTER_BITS'(1);
                    end
                end else if (ctr_q[idx_u] != '0) begin
                    ent_ctr_d = ctr_q[idx_u] - COUNTER_BITS'(1);
                end
            end else if (update_taken_i) begin
                // Allocate or replace the aliased entry
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = tag_u;
                ent_target_d = update_target_i;
                ent_ctr_d    = CTR_WT;
            end

            if (branch_cnt_q != STAT_MAX) begin
                branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
            end
            if (update_mispredict_i && (mispred_cnt_q != STAT_MAX)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_WIDTH'(1);
            end
        end
    end

    // State registers: rst > flush_i > update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WT;
            end
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WT;
            end
        end else begin
            if (ent_we) begin
                valid_q[idx_u]  <= ent_valid_d;
                tag_q[idx_u]    <= ent_tag_d;
                target_q[idx_u] <= ent_target_d;
                ctr_q[idx_u]    <= ent_ctr_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] PCF_i;
    logic        predict_taken_o;
    logic [31:0] predict_pc_o;
    logic        update_en_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic [31:0] update_target_i;
    logic        update_mispredict_i;
    logic [31:0] branch_count_o;
    logic [31:0] mispredict_count_o;

    int vectors = 0;
    int miscompares = 0;

    branch_predictor #(
        .DATA_WIDTH(32), .ENTRIES(16), .COUNTER_BITS(2), .STAT_WIDTH(32)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush_i),
        .PCF_i               (PCF_i),
        .predict_taken_o     (predict_taken_o),
        .predict_pc_o        (predict_pc_o),
        .update_en_i         (update_en_i),
        .update_pc_i         (update_pc_i),
        .update_taken_i      (update_taken_i),
        .update_target_i     (update_target_i),
        .update_mispredict_i (update_mispredict_i),
        .branch_count_o      (branch_count_o),
        .mispredict_count_o  (mispredict_count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Look up pc and compare both prediction outputs
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_pc);
        PCF_i = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, predict_taken_o}, {31'd0, exp_t});
        chk({tag, "_pc"}, predict_pc_o, exp_pc);
    endtask

    task automatic stats(input string tag, input logic [31:0] bc, input logic [31:0] mc);
        chk({tag, "_bc"}, branch_count_o, bc);
        chk({tag, "_mc"}, mispredict_count_o, mc);
    endtask

    // One-cycle update pulse
    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic mis);
        update_en_i = 1'b1;
        update_pc_i = pc;
        update_taken_i = taken;
        update_target_i = tgt;
        update_mispredict_i = mis;
        tick();
        update_en_i = 1'b0;
        update_mispredict_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        PCF_i = 32'h44;
        update_en_i = 1'b0;
        update_pc_i = '0;
        update_taken_i = 1'b0;
        update_target_i = '0;
        update_mispredict_i = 1'b0;
        tick();
        tick();
        look("reset", 32'h44, 1'b0, 32'h48);
        stats("reset", 0, 0);
        rst = 1'b0;
        tick();

        // First training with same-cycle lookup: pre-update state seen
        update_en_i = 1'b1;
        update_pc_i = 32'h44;
        update_taken_i = 1'b1;
        update_target_i = 32'h100;
        update_mispredict_i = 1'b1;
        look("same_cycle", 32'h44, 1'b0, 32'h48);
        tick();
        update_en_i = 1'b0;
        update_mispredict_i = 1'b0;
        look("first_train", 32'h44, 1'b1, 32'h100);
        stats("first_train", 1, 1);

        // Three taken: 2->3->3->3
        repeat (3) upd(32'h44, 1'b1, 32'h100, 1'b0);
        look("sat_hi", 32'h44, 1'b1, 32'h100);
        stats("sat_hi", 4, 1);

        // Not-taken: 3->2 (still taken), 2->1 (not taken)
        upd(32'h44, 1'b0, 32'h0, 1'b0);
        look("dec_to2", 32'h44, 1'b1, 32'h100);
        upd(32'h44, 1'b0, 32'h0, 1'b0);
        look("dec_to1", 32'h44, 1'b0, 32'h48);

        // 1->0->0, then one taken to 1: must still predict not-taken
        repeat (2) upd(32'h44, 1'b0, 32'h0, 1'b0);
        upd(32'h44, 1'b1, 32'h100, 1'b0);
        look("sat_lo", 32'h44, 1'b0, 32'h48);
        // 1->2 and hit-taken refreshes the target
        upd(32'h44, 1'b1, 32'h140, 1'b0);
        look("tgt_refresh", 32'h44, 1'b1, 32'h140);
        stats("train", 10, 1);

        // Aliasing: 0x84 shares index 1 with tag 2, replaces 0x44
        upd(32'h84, 1'b1, 32'h200, 1'b1);
        look("alias_new", 32'h84, 1'b1, 32'h200);
        look("alias_old", 32'h44, 1'b0, 32'h48);
        stats("alias", 11, 2);

        // Not-taken miss to 0xC4 leaves the entry alone
        upd(32'hC4, 1'b0, 32'h300, 1'b0);
        look("nt_miss_keep", 32'h84, 1'b1, 32'h200);
        look("nt_miss_noalloc", 32'hC4, 1'b0, 32'hC8);
        stats("nt_miss", 12, 2);

        // Fall-through wraps modulo 2^32
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Update inputs ignored while update_en_i is low
        update_pc_i = 32'h48;
        update_taken_i = 1'b1;
        update_target_i = 32'h400;
        update_mispredict_i = 1'b1;
        tick();
        update_mispredict_i = 1'b0;
        look("en_low", 32'h48, 1'b0, 32'h4C);
        stats("en_low", 12, 2);

        // Flush with coincident update: entries invalid, update dropped
        flush_i = 1'b1;
        upd(32'h44, 1'b1, 32'h100, 1'b1);
        flush_i = 1'b0;
        look("flush_44", 32'h44, 1'b0, 32'h48);
        look("flush_84", 32'h84, 1'b0, 32'h88);
        stats("flush", 12, 2);

        // Retrain after flush, then reset with a coincident update
        upd(32'h84, 1'b1, 32'h200, 1'b0);
        look("retrain", 32'h84, 1'b1, 32'h200);
        rst = 1'b1;
        upd(32'h44, 1'b1, 32'h100, 1'b1);
        rst = 1'b0;
        look("rst_44", 32'h44, 1'b0, 32'h48);
        look("rst_84", 32'h84, 1'b0, 32'h88);
        stats("rst_mid", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with N-bit saturating-counter direction prediction, for the next-generation pipelined RISC-V core.
- Fetch-stage lookup is combinational: it supplies the predicted next PC for the PC mux.
- The execute stage writes back the resolved outcome; training is synchronous on the next clock edge.
- Saturating statistics counters expose branch count and mispredict count for performance analysis.

Parameters:
- DATA_WIDTH, 32, PC and target width.
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- COUNTER_BITS, 2, width of each direction counter; minimum 1.
- STAT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  invalidate all entries (e.g. on fence.i).
- PCF_i  in  DATA_WIDTH  fetch-stage PC to look up.
- predict_taken_o  out  1  hit and counter predicts taken.
- predict_pc_o  out  DATA_WIDTH  stored target if predict_taken_o, else PCF_i+4.
- update_en_i  in  1  execute stage resolved a branch or jump this cycle.
- update_pc_i  in  DATA_WIDTH  PC of the resolved instruction.
- update_taken_i  in  1  actual outcome.
- update_target_i  in  DATA_WIDTH  actual target address.
- update_mispredict_i  in  1  pipeline redirected due to a wrong prediction.
- branch_count_o  out  STAT_WIDTH  number of accepted updates.
- mispredict_count_o  out  STAT_WIDTH  number of accepted updates with update_mispredict_i=1.

Behaviour:
- IDX = log2(ENTRIES).
- index = PC[IDX+1:2]; tag = PC[DATA_WIDTH-1:IDX+2]. PC[1:0] ignored.
- Per-entry state: valid (1 bit), tag, target (DATA_WIDTH), ctr (COUNTER_BITS).
- WT = 1<<(COUNTER_BITS-1) (weakly taken). MAX = all ones.
- Lookup (combinational, zero latency):
  - hit = valid[index] and tag matches.
  - predict_taken_o = hit and ctr[MSB].
  - predict_pc_o = target when predict_taken_o, else PCF_i+4, with wrap-around modulo 2^DATA_WIDTH.
- Update (registered; effect visible to lookups from the next cycle):
  - Miss (invalid or tag mismatch) and update_taken_i=1: allocate or replace. Set valid=1, tag, target=update_target_i, ctr=WT.
  - Miss and update_taken_i=0: no entry change.
  - Hit and taken: ctr=min(ctr+1, MAX); target=update_target_i.
  - Hit and not taken: ctr=max(ctr-1, 0); target and valid unchanged.
- Statistics, on each update_en_i=1:
  - branch_count_o increments.
  - mispredict_count_o increments when update_mispredict_i=1.
  - Both saturate at all ones; neither wraps.
- Simultaneous lookup and update to the same index: lookup returns pre-update state; no bypass.
- Priority: rst > flush_i > update_en_i.
  - rst: all valid=0, all ctr=WT, targets/tags=0, both statistics counters=0.
  - flush_i: all valid=0 and ctr=WT. The update in that cycle is dropped. Statistics are kept, except that a coincident update is not counted.
- Reset outputs: predict_taken_o=0; predict_pc_o=PCF_i+4; both statistics counters=0.
- Reset asserted mid-training: the update in that cycle is discarded; state takes reset values at the edge.
- Inputs to update ports are ignored while update_en_i=0.

Test Plan:
- Reset, PCF_i=0x44 → predict_taken_o=0, predict_pc_o=0x48, branch_count_o=0, mispredict_count_o=0.
- Update pc=0x44, taken=1, target=0x100, mispredict=1; next cycle PCF_i=0x44 → predict_taken_o=1, predict_pc_o=0x100, branch_count_o=1, mispredict_count_o=1.
- Counter saturation:
  - Three further taken updates on 0x44 → ctr=3.
  - Two not-taken updates → ctr=1; PCF_i=0x44 gives predict_taken_o=0, predict_pc_o=0x48.
  - Two further not-taken updates → ctr stays 0.
- Aliasing: after training 0x44, a taken update pc=0x84 (same index 1, tag 2), target=0x200 → 0x84 predicts 0x200, 0x44 predicts not-taken 0x48. A not-taken update to unallocated pc=0xC4 leaves the entry untouched.
- Same-cycle lookup/update on 0x44 first training → predict_taken_o=0 that cycle, 1 the next.
- flush_i asserted alongside an update for 0x44 → entry invalid, predict_pc_o=0x48, branch_count_o unchanged. Then assert rst while update_en_i=1 → all counts 0, no entry allocated.
